// File: rtl/chaos_key_streamer_pkg.sv
// -----------------------------------------------------------------------------
// chaos_key_pkg
// Purpose : Shared constants, state type and a small helper for the chaos key
//           streamer. Keys from the four-attractor generator are KEY_W bits
//           each and are streamed out in WORD_W-bit words, most significant
//           word of k1 first.
// Contents: KEY_W, WORD_W, NUM_KEYS, WORDS_PER_KEY, TOTAL_WORDS, derived
//           widths, STREAM_WORDS / LAST_IDX (stream length), ks_state_t,
//           key_of_idx() (word index -> owning key).
// Config  : KEY_STREAM_PARITY_EN adds one XOR-parity word to the stream.
// -----------------------------------------------------------------------------
package chaos_key_pkg;

    localparam int KEY_W         = 384;
    localparam int WORD_W        = 32;
    localparam int NUM_KEYS      = 4;
    localparam int WORDS_PER_KEY = KEY_W / WORD_W;            // 12
    localparam int TOTAL_WORDS   = NUM_KEYS * WORDS_PER_KEY;  // 48
    localparam int SHADOW_W      = NUM_KEYS * KEY_W;          // 1536
    localparam int IDX_W         = 6;
    localparam int KIDX_W        = 2;

`ifdef KEY_STREAM_PARITY_EN
    // One trailing word carrying the XOR of every key word.
    localparam int STREAM_WORDS  = TOTAL_WORDS + 1;
`else
    localparam int STREAM_WORDS  = TOTAL_WORDS;
`endif

    // Index of the first word past the key data (the parity slot when enabled).
    localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL_WORDS);
    // Index of the word that carries m_last_o.
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(STREAM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    // Key number a word index belongs to. Indices past the key data (the
    // parity slot) saturate to the last key.
    function automatic logic [KIDX_W-1:0] key_of_idx(input logic [IDX_W-1:0] idx);
        logic [KIDX_W-1:0] k;
        k = '0;
        for (int n = 1; n < NUM_KEYS; n++) begin
            if (idx >= IDX_W'(n * WORDS_PER_KEY)) begin
                k = KIDX_W'(n);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/chaos_key_streamer_if.sv
// -----------------------------------------------------------------------------
// chaos_key_streamer_if
// Purpose : Valid/ready word stream from the key streamer to the cipher stage.
// Signals : m_valid_o   word valid (source -> sink)
//           m_ready_i   sink ready (sink -> source)
//           m_data_o    WORD_W-bit word
//           m_last_o    final word of the stream
//           m_key_idx_o key (0..3) the word belongs to
// Modports: master (streamer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface chaos_key_streamer_if;
    import chaos_key_pkg::*;

    logic                m_valid_o;
    logic                m_ready_i;
    logic [WORD_W-1:0]   m_data_o;
    logic                m_last_o;
    logic [KIDX_W-1:0]   m_key_idx_o;

    modport master (
        output m_valid_o,
        output m_data_o,
        output m_last_o,
        output m_key_idx_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o,
        input  m_data_o,
        input  m_last_o,
        input  m_key_idx_o,
        output m_ready_i
    );

endinterface

// File: rtl/chaos_key_streamer_word_select.sv
// -----------------------------------------------------------------------------
// key_word_select
// Purpose : Combinational word mux. Picks word i_idx out of the packed shadow
//           {k1,k2,k3,k4}; index 0 is k1's most significant word. Indices past
//           the key data return 0 (the top substitutes the parity word there).
// Ports   : i_shadow  [SHADOW_W] captured keys
//           i_idx     [IDX_W]    word index
//           o_word    [WORD_W]   selected word
//           o_key_idx [KIDX_W]   key the index belongs to
// -----------------------------------------------------------------------------
module key_word_select
    import chaos_key_pkg::*;
(
    input  logic [SHADOW_W-1:0] i_shadow,
    input  logic [IDX_W-1:0]    i_idx,
    output logic [WORD_W-1:0]   o_word,
    output logic [KIDX_W-1:0]   o_key_idx
);

    logic [WORD_W-1:0] w_words [TOTAL_WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < TOTAL_WORDS; gi++) begin : g_word
            assign w_words[gi] = i_shadow[SHADOW_W-1-gi*WORD_W -: WORD_W];
        end
    endgenerate

    always_comb begin
        o_word = '0;
        if (i_idx < TOTAL_IDX) begin
            o_word = w_words[i_idx];
        end
    end

    assign o_key_idx = key_of_idx(i_idx);

endmodule

// File: rtl/chaos_key_streamer.sv
// -----------------------------------------------------------------------------
// chaos_key_streamer
// Purpose : Captures the four generator keys on the rising edge of the done
//           flag into a private shadow, then streams them as WORD_W-bit words
//           over a valid/ready interface. The generator may be reset or
//           re-seeded once the shadow is loaded; dropping the flag mid-stream
//           aborts the stream.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           key_flag_i         generator done flag (keys valid while high)
//           k1_i..k4_i [KEY_W] generator keys
//           m_if (master)      word stream: valid/ready/data/last/key_idx
//           busy_o             stream in progress
//           done_o             stream delivered, held until the flag falls
//           abort_o            one-cycle pulse when the flag drops mid-stream
// Config  : KEY_STREAM_PARITY_EN appends an XOR-of-all-words parity word.
// -----------------------------------------------------------------------------
module chaos_key_streamer
    import chaos_key_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_flag_i,
    input  logic [KEY_W-1:0]        k1_i,
    input  logic [KEY_W-1:0]        k2_i,
    input  logic [KEY_W-1:0]        k3_i,
    input  logic [KEY_W-1:0]        k4_i,
    chaos_key_streamer_if.master    m_if,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    abort_o
);

    ks_state_t           r_state, w_state_next;
    logic                r_flag_q;
    logic [SHADOW_W-1:0] r_shadow, w_shadow_next;
    logic [IDX_W-1:0]    r_idx, w_idx_next;
    logic                r_valid, w_valid_next;
    logic [WORD_W-1:0]   r_data, w_data_next;
    logic                r_last, w_last_next;
    logic [KIDX_W-1:0]   r_key_idx, w_key_idx_next;
    logic                r_abort, w_abort_next;
`ifdef KEY_STREAM_PARITY_EN
    logic [WORD_W-1:0]   r_parity, w_parity_next;
`endif

    logic                w_rise;
    logic                w_xfer;
    logic [IDX_W-1:0]    w_idx_inc;
    logic [WORD_W-1:0]   w_sel_word;
    logic [KIDX_W-1:0]   w_sel_key_idx;

    assign w_rise    = key_flag_i & ~r_flag_q;
    assign w_xfer    = r_valid & m_if.m_ready_i;
    assign w_idx_inc = r_idx + 1'b1;

    // The output registers are loaded with the word that follows the one
    // being accepted, so the mux looks one index ahead.
    key_word_select u_word_select (
        .i_shadow  (r_shadow),
        .i_idx     (w_idx_inc),
        .o_word    (w_sel_word),
        .o_key_idx (w_sel_key_idx)
    );

    // Next-state and datapath logic.
    always_comb begin
        w_state_next   = r_state;
        w_shadow_next  = r_shadow;
        w_idx_next     = r_idx;
        w_valid_next   = r_valid;
        w_data_next    = r_data;
        w_last_next    = r_last;
        w_key_idx_next = r_key_idx;
        w_abort_next   = 1'b0;
`ifdef KEY_STREAM_PARITY_EN
        w_parity_next  = r_parity;
`endif

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_next   = STREAM;
                    w_shadow_next  = {k1_i, k2_i, k3_i, k4_i};
                    w_idx_next     = '0;
                    w_valid_next   = 1'b1;
                    // The shadow loads on this same edge, so word 0 comes
                    // straight from the key input to keep valid at one cycle.
                    w_data_next    = k1_i[KEY_W-1 -: WORD_W];
                    w_key_idx_next = '0;
                    w_last_next    = (LAST_IDX == '0);
`ifdef KEY_STREAM_PARITY_EN
                    w_parity_next  = '0;
`endif
                end
            end

            STREAM: begin
                if (w_xfer && r_last) begin
                    // Whole stream delivered; a simultaneous flag drop is
                    // handled from DONE on the next edge.
                    w_state_next = DONE;
                    w_valid_next = 1'b0;
                    w_last_next  = 1'b0;
                end else if (!key_flag_i) begin
                    // Any transfer handshaking on this edge is already taken
                    // by the sink; nothing further is presented.
                    w_state_next = IDLE;
                    w_valid_next = 1'b0;
                    w_last_next  = 1'b0;
                    w_abort_next = 1'b1;
                end else if (w_xfer) begin
                    w_idx_next     = w_idx_inc;
                    w_data_next    = w_sel_word;
                    w_key_idx_next = w_sel_key_idx;
                    w_last_next    = (w_idx_inc == LAST_IDX);
`ifdef KEY_STREAM_PARITY_EN
                    w_parity_next  = r_parity ^ r_data;
                    if (w_idx_inc == TOTAL_IDX) begin
                        w_data_next = r_parity ^ r_data;
                    end
`endif
                end
            end

            DONE: begin
                if (!key_flag_i) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_valid_next = 1'b0;
                w_last_next  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_q  <= 1'b0;
            r_shadow  <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_key_idx <= '0;
            r_abort   <= 1'b0;
`ifdef KEY_STREAM_PARITY_EN
            r_parity  <= '0;
`endif
        end else begin
            r_flag_q  <= key_flag_i;
            r_shadow  <= w_shadow_next;
            r_idx     <= w_idx_next;
            r_valid   <= w_valid_next;
            r_data    <= w_data_next;
            r_last    <= w_last_next;
            r_key_idx <= w_key_idx_next;
            r_abort   <= w_abort_next;
`ifdef KEY_STREAM_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    assign m_if.m_valid_o   = r_valid;
    assign m_if.m_data_o    = r_data;
    assign m_if.m_last_o    = r_last;
    assign m_if.m_key_idx_o = r_key_idx;

    assign busy_o  = (r_state == STREAM);
    assign done_o  = (r_state == DONE);
    assign abort_o = r_abort;

endmodule

// File: tb/tb_chaos_key_streamer.sv
// -----------------------------------------------------------------------------
// tb_chaos_key_streamer
// Scoreboard bench: stimulus pushes the expected word stream into a queue, a
// monitor pops and compares every accepted word. Key patterns are chosen so
// each expected word is known by hand (base + word-within-key).
// Build with +define+KEY_STREAM_PARITY_EN to exercise the parity word.
// -----------------------------------------------------------------------------
module tb_chaos_key_streamer;

    localparam int NW  = 48;
    localparam int WPK = 12;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  kidx;
        logic        last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_flag;
    logic [383:0] k1, k2, k3, k4;
    logic         busy, done, abort;

    chaos_key_streamer_if m_if ();

    chaos_key_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .key_flag_i (key_flag),
        .k1_i       (k1),
        .k2_i       (k2),
        .k3_i       (k3),
        .k4_i       (k4),
        .m_if       (m_if),
        .busy_o     (busy),
        .done_o     (done),
        .abort_o    (abort)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    logic [31:0] exp_words [NW];
    int          errors    = 0;
    int          checks    = 0;
    int          xfer_cnt  = 0;
    int          rdy_mode  = 0;   // 0: always ready, 1: toggle with stall at word 20
    int          stall_cnt = 0;
    bit          stall_chk = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Expected words: word j of key n is base_n + j.
    task automatic pattern_bases(input logic [31:0] b1, b2, b3, b4);
        logic [31:0] b [4];
        b[0] = b1; b[1] = b2; b[2] = b3; b[3] = b4;
        for (int w = 0; w < NW; w++) exp_words[w] = b[w / WPK] + 32'(w % WPK);
    endtask

    task automatic pattern_fill(input logic [31:0] v);
        for (int w = 0; w < NW; w++) exp_words[w] = v;
    endtask

    task automatic apply_keys();
        for (int j = 0; j < WPK; j++) begin
            k1[383-32*j -: 32] = exp_words[j];
            k2[383-32*j -: 32] = exp_words[WPK + j];
            k3[383-32*j -: 32] = exp_words[2*WPK + j];
            k4[383-32*j -: 32] = exp_words[3*WPK + j];
        end
    endtask

    task automatic push_expected();
        exp_t        e;
        logic [31:0] par;
        par = '0;
        for (int w = 0; w < NW; w++) begin
            e.data = exp_words[w];
            e.kidx = 2'(w / WPK);
`ifdef KEY_STREAM_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (w == NW - 1);
`endif
            par = par ^ exp_words[w];
            sb_q.push_back(e);
        end
`ifdef KEY_STREAM_PARITY_EN
        e.data = par;
        e.kidx = 2'd3;
        e.last = 1'b1;
        sb_q.push_back(e);
`endif
    endtask

    // Raise the flag and check the one-cycle capture latency.
    task automatic raise_flag();
        @(posedge clk); #1;
        key_flag = 1'b1;
        @(negedge clk); #1;
        check("valid_before_capture", 64'(m_if.m_valid_o), 64'd0);
        @(negedge clk); #1;
        check("valid_after_capture", 64'({m_if.m_valid_o, busy}), 64'b11);
    endtask

    task automatic drop_flag();
        @(posedge clk); #1;
        key_flag = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #1;
            if (sb_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d words left expected 0", name, sb_q.size());
        end
        @(negedge clk); #1;
        check({name, "_done"}, 64'({done, m_if.m_valid_o, busy}), 64'b100);
    endtask

    task automatic wait_xfer(input int n);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #1;
            if (xfer_cnt >= n) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_xfer: got %0d transfers expected %0d", xfer_cnt, n);
    endtask

    // Ready driver.
    initial begin
        m_if.m_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) begin
                m_if.m_ready_i = 1'b1;
            end else if (xfer_cnt == 20 && stall_cnt < 5) begin
                m_if.m_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                m_if.m_ready_i = ~m_if.m_ready_i;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted word.
    initial begin
        exp_t        e;
        bit          prev_stall;
        logic [31:0] held_data;
        logic [1:0]  held_kidx;
        logic        held_last;
        prev_stall = 0;
        held_data  = '0;
        held_kidx  = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_chk && prev_stall && !rst) begin
                check("stall_hold", 64'({m_if.m_valid_o, m_if.m_data_o, m_if.m_key_idx_o, m_if.m_last_o}),
                      64'({1'b1, held_data, held_kidx, held_last}));
            end
            if (!rst && m_if.m_valid_o && m_if.m_ready_i) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected no word", m_if.m_data_o);
                end else begin
                    e = sb_q.pop_front();
                    $display("xfer %0d: data=%08h kidx=%0d last=%0b", xfer_cnt, m_if.m_data_o,
                             m_if.m_key_idx_o, m_if.m_last_o);
                    check("word", 64'({m_if.m_data_o, m_if.m_key_idx_o, m_if.m_last_o}),
                          64'({e.data, e.kidx, e.last}));
                end
                xfer_cnt++;
            end
            prev_stall = !rst && m_if.m_valid_o && !m_if.m_ready_i;
            held_data  = m_if.m_data_o;
            held_kidx  = m_if.m_key_idx_o;
            held_last  = m_if.m_last_o;
        end
    end

    // Watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        rst      = 1'b1;
        key_flag = 1'b0;
        k1 = '0; k2 = '0; k3 = '0; k4 = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 64'({m_if.m_valid_o, m_if.m_data_o, m_if.m_last_o, m_if.m_key_idx_o,
                                   busy, done, abort}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic stream at full rate.
        pattern_bases(32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000);
        apply_keys();
        xfer_cnt = 0;
        push_expected();
        raise_flag();
        wait_done("t1");
        drop_flag();

        // 2: toggling ready with a 5-cycle stall on word 20.
        rdy_mode  = 1;
        stall_cnt = 0;
        stall_chk = 1;
        xfer_cnt  = 0;
        push_expected();
        raise_flag();
        wait_done("t2");
        check("t2_stall_seen", 64'(stall_cnt), 64'd5);
        stall_chk = 0;
        rdy_mode  = 0;
        drop_flag();

        // 3: abort after 10 transfers, then recapture new keys.
        xfer_cnt = 0;
        push_expected();
        raise_flag();
        wait_xfer(10);
        key_flag = 1'b0;
        sb_q.delete();
        @(negedge clk); #1;
        check("t3_abort", 64'({abort, m_if.m_valid_o, busy, done}), 64'b1000);
        @(negedge clk); #1;
        check("t3_abort_pulse", 64'(abort), 64'd0);
        check("t3_xfers", 64'(xfer_cnt), 64'd10);
        pattern_bases(32'h5000_0000, 32'h6000_0000, 32'h7000_0000, 32'h8000_0000);
        apply_keys();
        xfer_cnt = 0;
        push_expected();
        raise_flag();
        wait_done("t3");
        drop_flag();

        // 4: reset at word 30, release with flag high.
        pattern_bases(32'h9000_0000, 32'hA000_0000, 32'hB000_0000, 32'hC000_0000);
        apply_keys();
        xfer_cnt = 0;
        push_expected();
        raise_flag();
        wait_xfer(30);
        sb_q.delete();
        rst = 1'b1;
        @(negedge clk); #1;
        check("t4_reset_outputs", 64'({m_if.m_valid_o, m_if.m_data_o, m_if.m_last_o, m_if.m_key_idx_o,
                                      busy, done, abort}), 64'd0);
        pattern_bases(32'hD000_0000, 32'hE000_0000, 32'hF000_0000, 32'h0100_0000);
        apply_keys();
        xfer_cnt = 0;
        push_expected();
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done("t4");

        // 6: flag held high after done must not restart.
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (m_if.m_valid_o || !done) bad++;
        end
        check("t6_no_restart", 64'(bad), 64'd0);
        drop_flag();
        check("t6_idle_after_fall", 64'({done, busy}), 64'b00);
        pattern_bases(32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000);
        apply_keys();
        xfer_cnt = 0;
        push_expected();
        raise_flag();
        wait_done("t6");
        drop_flag();

`ifdef KEY_STREAM_PARITY_EN
        // 5: parity word.
        pattern_fill(32'h0);
        exp_words[NW-1] = 32'hDEAD_BEEF;
        apply_keys();
        xfer_cnt = 0;
        push_expected();
        check("t5_parity_model", 64'(sb_q[NW].data), 64'hDEAD_BEEF);
        raise_flag();
        wait_done("t5a");
        check("t5_len", 64'(xfer_cnt), 64'd49);
        drop_flag();
        pattern_fill(32'hFFFF_FFFF);
        apply_keys();
        xfer_cnt = 0;
        push_expected();
        check("t5_parity_ones_model", 64'(sb_q[NW].data), 64'h0);
        raise_flag();
        wait_done("t5b");
        drop_flag();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
